csi2_mux_sched: RTL

//   Time-division scheduler for the CSI-2 4:1 lane mux. Picks which of four camera

---
 rtl/csi2_mux_sched_if.sv | 37 +++
 rtl/csi2_mux_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/csi2_mux_sched_if.sv
// Signal bundle between the sensor control logic and the CSI-2 lane-mux scheduler.
// Latency: none, wires only.
// Backpressure: none, all signals are level or single-cycle pulses; force_* exist only with CSI2_MUX_SCHED_FORCE_EN.
interface csi2_mux_sched_if;
    logic [3:0] ch_en_i;
    logic       frame_end_i;
    logic       lp_idle_i;
`ifdef CSI2_MUX_SCHED_FORCE_EN
    logic       force_en_i;
    logic [1:0] force_sel_i;
`endif
    logic [1:0] mux_sel_o;
    logic       mux_rst_n_o;
    logic [3:0] ch_active_o;
    logic       switch_o;
    logic       busy_o;

`ifdef CSI2_MUX_SCHED_FORCE_EN
    modport master (
        output ch_en_i, frame_end_i, lp_idle_i, force_en_i, force_sel_i,
        input  mux_sel_o, mux_rst_n_o, ch_active_o, switch_o, busy_o
    );
    modport slave (
        input  ch_en_i, frame_end_i, lp_idle_i, force_en_i, force_sel_i,
        output mux_sel_o, mux_rst_n_o, ch_active_o, switch_o, busy_o
    );
`else
    modport master (
        output ch_en_i, frame_end_i, lp_idle_i,
        input  mux_sel_o, mux_rst_n_o, ch_active_o, switch_o, busy_o
    );
    modport slave (
        input  ch_en_i, frame_end_i, lp_idle_i,
        output mux_sel_o, mux_rst_n_o, ch_active_o, switch_o, busy_o
    );
`endif
endinterface

// File: rtl/csi2_mux_sched.sv
// Time-division scheduler driving select/reset of a 4:1 CSI-2 lane mux; switches only at frame ends after an LP-11 guard.
// Latency: all outputs registered; switch_o one cycle after the deciding input, mux_rst_n_o rises SETTLE_CYC+1 cycles after switch_o.
// Backpressure: none; optional CSI2_MUX_SCHED_FORCE_EN adds force_en_i/force_sel_i to pin the next channel.
module csi2_mux_sched #(
    parameter int unsigned FRAMES_PER_CH = 1,
    parameter int unsigned GUARD_CYC     = 16,
    parameter int unsigned SETTLE_CYC    = 32
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    csi2_mux_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [7:0] FRM_LIM    = 8'(FRAMES_PER_CH);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYC - 1);
    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] rr_q, rr_d;
    logic [7:0] frm_q, frm_d;
    logic [7:0] cyc_q, cyc_d;
    logic       rst_n_q, rst_n_d;
    logic [3:0] act_q, act_d;
    logic       sw_q, sw_d;
    logic       busy_q, busy_d;

    logic       force_en_w;
    logic [1:0] force_sel_w;
    logic [1:0] next_ch;
    logic       others_en;

`ifdef CSI2_MUX_SCHED_FORCE_EN
    assign force_en_w  = bus.force_en_i;
    assign force_sel_w = bus.force_sel_i;
`else
    assign force_en_w  = 1'b0;
    assign force_sel_w = 2'd0;
`endif

    // First enabled channel after ptr, wrapping round to ptr itself last.
    function automatic logic [1:0] rr_pick(input logic [3:0] en, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       hit;
        pick = ptr;
        hit  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!hit && en[cand]) begin
                pick = cand;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign next_ch   = force_en_w ? force_sel_w : rr_pick(bus.ch_en_i, rr_q);
    assign others_en = |(bus.ch_en_i & ~(4'b0001 << sel_q));

    // Next-state logic: scheduling decisions plus registered-output images derived from the next state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        frm_d   = frm_q;
        cyc_d   = cyc_q;
        sw_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                frm_d = 8'd0;
                cyc_d = 8'd0;
                if ((bus.ch_en_i != 4'd0) || force_en_w) begin
                    sel_d   = next_ch;
                    rr_d    = next_ch;
                    sw_d    = 1'b1;
                    state_d = S_SETTLE;
                end
            end

            // Runs to completion whatever ch_en_i does; cyc_q counts cycles since the select load.
            S_SETTLE: begin
                if (cyc_q >= SETTLE_LIM) begin
                    cyc_d   = 8'd0;
                    state_d = S_ACTIVE;
                end else begin
                    cyc_d = sat_inc(cyc_q);
                end
            end

            // Losing the enable (or a forced retarget) beats a same-cycle frame end.
            S_ACTIVE: begin
                if (!force_en_w && !bus.ch_en_i[sel_q]) begin
                    frm_d   = 8'd0;
                    cyc_d   = 8'd0;
                    state_d = S_DRAIN;
                end else if (force_en_w && (force_sel_w != sel_q)) begin
                    frm_d   = 8'd0;
                    cyc_d   = 8'd0;
                    state_d = S_DRAIN;
                end else if (bus.frame_end_i) begin
                    if (sat_inc(frm_q) >= FRM_LIM) begin
                        frm_d = 8'd0;
                        if (!force_en_w && others_en) begin
                            cyc_d   = 8'd0;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        frm_d = sat_inc(frm_q);
                    end
                end
            end

            // cyc_q counts consecutive LP-11 cycles; any non-idle cycle restarts the guard.
            S_DRAIN: begin
                if (!bus.lp_idle_i) begin
                    cyc_d = 8'd0;
                end else if (cyc_q >= GUARD_LAST) begin
                    cyc_d = 8'd0;
                    if (!force_en_w && (bus.ch_en_i == 4'd0)) begin
                        state_d = S_IDLE;
                    end else if (next_ch == sel_q) begin
                        state_d = S_ACTIVE;
                    end else begin
                        sel_d   = next_ch;
                        rr_d    = next_ch;
                        sw_d    = 1'b1;
                        state_d = S_SETTLE;
                    end
                end else begin
                    cyc_d = sat_inc(cyc_q);
                end
            end

            default: state_d = S_IDLE;
        endcase

        rst_n_d = (state_d == S_ACTIVE) || (state_d == S_DRAIN);
        act_d   = rst_n_d ? (4'b0001 << sel_d) : 4'b0000;
        busy_d  = (state_d == S_SETTLE) || (state_d == S_DRAIN);
    end

    // State and output registers; reset forces the parked, mux-in-reset condition immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            rr_q    <= 2'd3;
            frm_q   <= 8'd0;
            cyc_q   <= 8'd0;
            rst_n_q <= 1'b0;
            act_q   <= 4'd0;
            sw_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            frm_q   <= frm_d;
            cyc_q   <= cyc_d;
            rst_n_q <= rst_n_d;
            act_q   <= act_d;
            sw_q    <= sw_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.mux_sel_o   = sel_q;
    assign bus.mux_rst_n_o = rst_n_q;
    assign bus.ch_active_o = act_q;
    assign bus.switch_o    = sw_q;
    assign bus.busy_o      = busy_q;

endmodule
